// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
//   state_e     - sequencer states (idle, access strobe, read wait, response)
//   OWN_*       - owner encoding used by the picker and the sequencer
//   RD_LAT_*    - legal bounds of the memory read latency parameter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: two-way round-robin picker.
//   cpu_req, ldr_req - raw requests
//   last_owner       - owner of the most recent grant
//   lock_mask        - when high the CPU request is ignored
//   owner            - winning requester (OWN_CPU / OWN_LDR), valid when any = 1
//   any              - at least one eligible request
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic last_owner,
    input  logic lock_mask,
    output logic owner,
    output logic any
);

    logic cpu_ok;

    assign cpu_ok = cpu_req & ~lock_mask;
    assign any    = cpu_ok | ldr_req;

    always_comb begin
        owner = OWN_CPU;
        if (cpu_ok && ldr_req) begin
            // Tie: whoever was not served last goes first.
            owner = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (ldr_req) begin
            owner = OWN_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified memory between the CPU port and
// the loader/debug port. Serialises accesses, drives the memory strobe/address/data,
// waits out the fixed read latency and returns read data with one-cycle pulses.
//   clk, reset                 - clock, asynchronous active-high reset
//   cpu_* / ldr_*              - request side: req/we/addr/wdata in, gnt/rvalid/rdata out
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata       - memory side
//   busy                       - high whenever the sequencer is not idle
//   ldr_lock                   - only with MEM_ARB_LOCK_EN: keeps the memory with the
//                                loader while it remains the owner
// Configuration macro: MEM_ARB_LOCK_EN (undefined = pure round-robin).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic          ldr_lock,
`endif
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT out of range");
    end

    // WAIT lasts RD_LAT cycles: load RD_LAT-1 and leave when the counter hits zero.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_e     state_q;
    logic       owner_q;
    logic       last_owner_q;
    logic       we_q;
    logic [1:0] cnt_q;

    logic       pick_owner;
    logic       pick_any;
    logic       lock_mask;

`ifdef MEM_ARB_LOCK_EN
    assign lock_mask = ldr_lock && (last_owner_q == OWN_LDR);
`else
    assign lock_mask = 1'b0;
`endif

    mem_arb_rr_pick u_pick (
        .cpu_req    (cpu_req),
        .ldr_req    (ldr_req),
        .last_owner (last_owner_q),
        .lock_mask  (lock_mask),
        .owner      (pick_owner),
        .any        (pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_LDR;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            cpu_gnt      <= 1'b0;
            ldr_gnt      <= 1'b0;
            cpu_rvalid   <= 1'b0;
            ldr_rvalid   <= 1'b0;
            cpu_rdata    <= '0;
            ldr_rdata    <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            // Pulses default low; each state raises only what it owns.
            cpu_gnt    <= 1'b0;
            ldr_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        owner_q      <= pick_owner;
                        last_owner_q <= pick_owner;
                        we_q         <= (pick_owner == OWN_LDR) ? ldr_we : cpu_we;
                        mem_addr     <= (pick_owner == OWN_LDR) ? ldr_addr : cpu_addr;
                        mem_wdata    <= (pick_owner == OWN_LDR) ? ldr_wdata : cpu_wdata;
                        mem_we       <= (pick_owner == OWN_LDR) ? ldr_we : cpu_we;
                        mem_en       <= 1'b1;
                        cpu_gnt      <= (pick_owner == OWN_CPU);
                        ldr_gnt      <= (pick_owner == OWN_LDR);
                        busy         <= 1'b1;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    if (we_q) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= LAT_LOAD;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 2'd0) begin
                        if (owner_q == OWN_LDR) begin
                            ldr_rdata  <= mem_rdata;
                            ldr_rvalid <= 1'b1;
                        end else begin
                            cpu_rdata  <= mem_rdata;
                            cpu_rvalid <= 1'b1;
                        end
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StResp: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
